// File: rtl/nn_pkg.sv
// Shared types and helpers for the time-multiplexed neuron layer.
// Build option NEURON_LAYER_BIAS_EN adds per-neuron bias registers.
package nn_pkg;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    localparam int RS_W = 64;

    function automatic int calc_acc_w(input int n_in, input int dw, input int ww);
        int w;
        w = dw + ww + $clog2(n_in) + 1;
`ifdef NEURON_LAYER_BIAS_EN
        w = w + 1;
`endif
        return w;
    endfunction

    function automatic int calc_aw(input int n_in, input int n_out);
        int a;
`ifdef NEURON_LAYER_BIAS_EN
        a = $clog2(n_in * n_out + n_out);
`else
        a = $clog2(n_in * n_out);
`endif
        return (a < 1) ? 1 : a;
    endfunction

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Negative sums clamp to zero, sums above the OW-bit range clip to all-ones.
    function automatic logic [RS_W-1:0] relu_sat(input logic signed [RS_W-1:0] acc,
                                                 input int ow, output logic sat);
        logic signed [RS_W-1:0] maxv;
        maxv = (64'sd1 <<< ow) - 64'sd1;
        sat = 1'b0;
        relu_sat = '0;
        if (acc < 0) begin
            relu_sat = '0;
        end else if (acc > maxv) begin
            relu_sat = maxv;
            sat = 1'b1;
        end else begin
            relu_sat = acc;
        end
    endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Shared signed multiply-accumulate datapath with ReLU/saturating output view.
// The first product of each neuron starts from base_i instead of the running sum.
module nn_mac_unit
    import nn_pkg::*;
#(
    parameter int DW    = 4,
    parameter int WW    = 4,
    parameter int OW    = 10,
    parameter int ACC_W = 11
) (
    input  logic                    clk_i,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic                    first_i,
    input  logic signed [ACC_W-1:0] base_i,
    input  logic [DW-1:0]           x_i,
    input  logic signed [WW-1:0]    w_i,
    output logic [OW-1:0]           y_o,
    output logic                    sat_o
);

    logic signed [DW+WW:0]    prod_p0;
    logic signed [ACC_W-1:0]  sum_p0;
    logic signed [ACC_W-1:0]  acc_p1;
    logic [RS_W-1:0]          rs_p0;
    logic                     unused_hi;

    assign prod_p0 = $signed({1'b0, x_i}) * w_i;
    assign sum_p0  = (first_i ? base_i : acc_p1) + ACC_W'(prod_p0);

    always_comb begin
        rs_p0 = relu_sat(RS_W'(sum_p0), OW, sat_o);
    end

    assign y_o       = rs_p0[OW-1:0];
    assign unused_hi = |rs_p0[RS_W-1:OW];

    // p0 -> p1: running sum register
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            acc_p1 <= '0;
        end else if (en_i) begin
            acc_p1 <= sum_p0;
        end
    end

endmodule

// File: rtl/neuron_layer_mac.sv
// Fully-connected layer, N_OUT neurons x N_IN inputs, one product per enabled cycle.
// Build option NEURON_LAYER_BIAS_EN adds bias registers at addresses N_IN*N_OUT + j.
module neuron_layer_mac
    import nn_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 8,
    parameter int DW    = 4,
    parameter int WW    = 4,
    parameter int OW    = 10,
    localparam int ACC_W = calc_acc_w(N_IN, DW, WW),
    localparam int AW    = calc_aw(N_IN, N_OUT)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [WW-1:0]         wr_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [N_IN*DW-1:0]    x_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [N_OUT*OW-1:0]   y_o,
    output logic                  busy_o,
    output logic                  sat_o
);

    localparam int NW = N_IN * N_OUT;
    localparam int KW = cnt_w(N_IN);
    localparam int JW = cnt_w(N_OUT);

    state_t                   state_q, state_d;
    logic [KW-1:0]            k_q;
    logic [JW-1:0]            j_q;
    logic signed [WW-1:0]     w_q [NW];
    logic [N_IN*DW-1:0]       x_p0;
    logic [N_OUT*OW-1:0]      y_q;
    logic                     sat_q;
    logic                     accept, step, last_k, last_j, wr_ok;
    logic [DW-1:0]            x_cur;
    logic signed [WW-1:0]     w_cur;
    logic signed [ACC_W-1:0]  base;
    logic [OW-1:0]            mac_y;
    logic                     mac_sat;

    assign in_ready_o  = (state_q == IDLE);
    assign busy_o      = (state_q == MAC);
    assign out_valid_o = (state_q == DONE);
    assign y_o         = y_q;
    assign sat_o       = sat_q;

    assign accept = in_ready_o & in_valid_i & en_i;
    assign step   = busy_o & en_i;
    assign last_k = (int'(k_q) == N_IN - 1);
    assign last_j = (int'(j_q) == N_OUT - 1);
    assign wr_ok  = wr_en_i & (state_q != MAC);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MAC;
            MAC:     if (step && last_k && last_j) state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                k_q <= '0;
                j_q <= '0;
            end else if (step) begin
                if (last_k) begin
                    k_q <= '0;
                    j_q <= last_j ? '0 : j_q + 1'b1;
                end else begin
                    k_q <= k_q + 1'b1;
                end
            end
        end
    end

    // Operand selection for the current (j, k) product
    always_comb begin
        x_cur = '0;
        w_cur = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (int'(k_q) == i) x_cur = x_p0[i*DW +: DW];
        end
        for (int i = 0; i < NW; i++) begin
            if (int'(j_q) * N_IN + int'(k_q) == i) w_cur = w_q[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NW; i++) w_q[i] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NW; i++) begin
                if (int'(wr_addr_i) == i) w_q[i] <= wr_data_i;
            end
        end
    end

`ifdef NEURON_LAYER_BIAS_EN
    logic signed [WW-1:0] bias_q [N_OUT];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_OUT; i++) bias_q[i] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (int'(wr_addr_i) == NW + i) bias_q[i] <= wr_data_i;
            end
        end
    end

    always_comb begin
        base = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (int'(j_q) == i) base = ACC_W'(bias_q[i]);
        end
    end
`else
    assign base = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (accept) x_p0 <= x_i;
    end

    nn_mac_unit #(
        .DW    (DW),
        .WW    (WW),
        .OW    (OW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk_i   (clk_i),
        .clr_i   (accept),
        .en_i    (step),
        .first_i (k_q == '0),
        .base_i  (base),
        .x_i     (x_cur),
        .w_i     (w_cur),
        .y_o     (mac_y),
        .sat_o   (mac_sat)
    );

    // Neuron write-back and sticky clip flag, cleared per transaction
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            y_q   <= '0;
            sat_q <= 1'b0;
        end else if (accept) begin
            sat_q <= 1'b0;
        end else if (step && last_k) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (int'(j_q) == i) y_q[i*OW +: OW] <= mac_y;
            end
            if (mac_sat) sat_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_neuron_layer_mac.sv
// Bench for neuron_layer_mac: table vectors plus hand sequences, scoreboard queue.
// Runs an OW=10 and an OW=8 instance side by side on identical stimulus.
module tb_neuron_layer_mac;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [3:0]  wr_data = '0;
    logic        in_valid = 1'b0;
    logic [15:0] x = '0;
    logic        out_ready = 1'b0;

    logic        in_ready10, out_valid10, busy10, sat10;
    logic [79:0] y10;
    logic        in_ready8, out_valid8, busy8, sat8;
    logic [63:0] y8;

    int cyc = 0;
    int acc_cyc = 0;
    int total = 0;
    int bad = 0;
    int w_m [32];

    typedef struct {
        logic [79:0] y10;
        logic [63:0] y8;
        logic        s10;
        logic        s8;
    } exp_t;

    typedef struct {
        int         w0, w1, w2, w3;
        logic [3:0] xv;
        int         e10;
        logic       s10;
        int         e8;
        logic       s8;
    } vec_t;

    exp_t exp_q[$];
    vec_t vt [6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neuron_layer_mac u_dut10 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .in_valid_i(in_valid), .in_ready_o(in_ready10), .x_i(x),
        .out_valid_o(out_valid10), .out_ready_i(out_ready), .y_o(y10), .busy_o(busy10),
        .sat_o(sat10)
    );

    neuron_layer_mac #(.OW(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .in_valid_i(in_valid), .in_ready_o(in_ready8), .x_i(x),
        .out_valid_o(out_valid8), .out_ready_i(out_ready), .y_o(y8), .busy_o(busy8),
        .sat_o(sat8)
    );

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [15:0] xv);
        exp_t r;
        int s, v10, v8;
        logic [9:0] t10;
        logic [7:0] t8;
        r.y10 = '0; r.y8 = '0; r.s10 = 1'b0; r.s8 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            s = 0;
            for (int k = 0; k < 4; k++) s += int'(xv[k*4 +: 4]) * w_m[j*4 + k];
            v10 = (s < 0) ? 0 : (s > 1023) ? 1023 : s;
            v8  = (s < 0) ? 0 : (s > 255) ? 255 : s;
            if (s > 1023) r.s10 = 1'b1;
            if (s > 255) r.s8 = 1'b1;
            t10 = v10[9:0];
            t8  = v8[7:0];
            r.y10[j*10 +: 10] = t10;
            r.y8[j*8 +: 8]    = t8;
        end
        return r;
    endfunction

    task automatic write_w(input int addr, input int data, input bit upd);
        wr_en   = 1'b1;
        wr_addr = 5'(addr);
        wr_data = 4'(data);
        wait_cycle();
        wr_en = 1'b0;
        if (upd) w_m[addr] = data;
    endtask

    task automatic do_accept(input logic [15:0] xv);
        bit ok, will;
        ok = 1'b0;
        x = xv;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            will = in_ready10 && en;
            wait_cycle();
            if (will) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        acc_cyc = cyc;
        check("accept_seen", 80'(ok), 80'd1);
    endtask

    task automatic collect(input int exp_lat, input int hold);
        bit got;
        exp_t e;
        got = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (out_valid10) begin
                got = 1'b1;
                break;
            end
            wait_cycle();
        end
        check("out_valid_seen", 80'(got), 80'd1);
        if (!got) return;
        check("latency", 80'(cyc - acc_cyc), 80'(exp_lat));
        check("exp_queue_nonempty", 80'(exp_q.size() > 0), 80'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("y_ow10", y10, e.y10);
        check("sat_ow10", 80'(sat10), 80'(e.s10));
        check("out_valid_ow8", 80'(out_valid8), 80'd1);
        check("y_ow8", 80'(y8), 80'(e.y8));
        check("sat_ow8", 80'(sat8), 80'(e.s8));
        for (int h = 0; h < hold; h++) begin
            wait_cycle();
            check("hold_valid", 80'(out_valid10), 80'd1);
            check("hold_y", y10, e.y10);
            check("hold_sat8", 80'(sat8), 80'(e.s8));
            check("hold_in_ready", 80'(in_ready10), 80'd0);
        end
        out_ready = 1'b1;
        wait_cycle();
        out_ready = 1'b0;
        check("valid_drop", 80'(out_valid10), 80'd0);
        check("y_retained", y10, e.y10);
    endtask

    initial begin
        exp_t e;
        logic [9:0] t10;
        logic [7:0] t8;

        vt[0] = '{1, 2, 3, 4, 4'hA, 100, 1'b0, 100, 1'b0};
        vt[1] = '{-8, -8, -8, -8, 4'hF, 0, 1'b0, 0, 1'b0};
        vt[2] = '{7, 7, 7, 7, 4'hF, 420, 1'b0, 255, 1'b1};
        vt[3] = '{7, 7, 7, 7, 4'h0, 0, 1'b0, 0, 1'b0};
        vt[4] = '{7, -8, 7, -8, 4'h9, 0, 1'b0, 0, 1'b0};
        vt[5] = '{3, 3, 3, 2, 4'hF, 165, 1'b0, 165, 1'b0};
        for (int i = 0; i < 32; i++) w_m[i] = 0;

        // reset state
        wait_cycle();
        wait_cycle();
        check("rst_out_valid", 80'(out_valid10), 80'd0);
        check("rst_busy", 80'({busy10, busy8}), 80'd0);
        check("rst_y10", y10, 80'd0);
        check("rst_y8", 80'(y8), 80'd0);
        check("rst_sat", 80'({sat10, sat8}), 80'd0);
        rst = 1'b0;
        wait_cycle();

        // table vectors: uniform weight pattern per neuron, all x equal
        for (int v = 0; v < 6; v++) begin
            for (int j = 0; j < 8; j++) begin
                write_w(j*4 + 0, vt[v].w0, 1'b1);
                write_w(j*4 + 1, vt[v].w1, 1'b1);
                write_w(j*4 + 2, vt[v].w2, 1'b1);
                write_w(j*4 + 3, vt[v].w3, 1'b1);
            end
            t10 = 10'(vt[v].e10);
            t8  = 8'(vt[v].e8);
            e.y10 = {8{t10}};
            e.y8  = {8{t8}};
            e.s10 = vt[v].s10;
            e.s8  = vt[v].s8;
            exp_q.push_back(e);
            do_accept({4{vt[v].xv}});
            collect(32, 0);
        end

        // distinct weights per (j,k), distinct inputs
        for (int j = 0; j < 8; j++)
            for (int k = 0; k < 4; k++)
                write_w(j*4 + k, ((j + 2*k) % 8) - 2, 1'b1);
        exp_q.push_back(model(16'hC7F3));
        do_accept(16'hC7F3);
        collect(32, 0);

        // weight write in the acceptance cycle is used by that transaction
        x = 16'h3B6E;
        in_valid = 1'b1;
        wr_en = 1'b1;
        wr_addr = 5'd0;
        wr_data = 4'd7;
        wait_cycle();
        in_valid = 1'b0;
        wr_en = 1'b0;
        acc_cyc = cyc;
        w_m[0] = 7;
        check("same_cycle_accept_busy", 80'(busy10), 80'd1);
        exp_q.push_back(model(16'h3B6E));
        collect(32, 0);

        // backpressure, dropped write during MAC, second request held off
        exp_q.push_back(model(16'hC7F3));
        do_accept(16'hC7F3);
        wait_cycle();
        wait_cycle();
        wait_cycle();
        write_w(1, -8, 1'b0);
        x = 16'h5AF1;
        in_valid = 1'b1;
        collect(32, 5);
        check("post_hs_in_ready", 80'({in_ready10, in_ready8}), 80'h3);
        check("post_hs_not_busy", 80'(busy10), 80'd0);
        wait_cycle();
        acc_cyc = cyc;
        check("second_accept_busy", 80'(busy10), 80'd1);
        in_valid = 1'b0;
        exp_q.push_back(model(16'h5AF1));
        collect(32, 0);

        // enable low for three cycles mid-MAC
        exp_q.push_back(model(16'h9E47));
        do_accept(16'h9E47);
        for (int i = 0; i < 10; i++) wait_cycle();
        en = 1'b0;
        for (int i = 0; i < 3; i++) wait_cycle();
        check("stall_busy", 80'(busy10), 80'd1);
        en = 1'b1;
        collect(35, 0);

        // asynchronous reset mid-MAC
        exp_q.push_back(model(16'hC7F3));
        do_accept(16'hC7F3);
        for (int i = 0; i < 10; i++) wait_cycle();
        check("pre_rst_busy", 80'(busy10), 80'd1);
        check("pre_rst_y_nonzero", 80'(y10 != 80'd0), 80'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 80'({out_valid10, out_valid8}), 80'd0);
        check("async_rst_busy", 80'({busy10, busy8}), 80'd0);
        check("async_rst_y10", y10, 80'd0);
        check("async_rst_y8", 80'(y8), 80'd0);
        wait_cycle();
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 32; i++) w_m[i] = 0;
        wait_cycle();
        exp_q.push_back(model(16'hFFFF));
        do_accept(16'hFFFF);
        collect(32, 0);

        check("queue_drained", 80'(exp_q.size()), 80'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/neuron_layer_mac.md
Name: neuron_layer_mac

Overview:
- Parametrised, time-multiplexed fully-connected layer.
- N_OUT neurons x N_IN inputs, computed with one shared multiply-accumulate unit, one product per cycle.
- Weights live in an internal writable register file.
- Replaces the fixed 4-input hidden-neuron instances. Sits between the input sample source and the output/loss stage, with valid/ready handshakes on both sides.

Parameters:
N_IN, 4, inputs per neuron (>=1)
N_OUT, 8, neurons in the layer (>=1)
DW, 4, unsigned input width
WW, 4, signed two's-complement weight width
OW, 10, unsigned output width per neuron
ACC_W, DW+WW+$clog2(N_IN)+1, signed accumulator width (derived; do not override)
AW, $clog2(N_IN*N_OUT), weight address width (derived)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
en_i  input  1  global enable; low stalls MAC progress
wr_en_i  input  1  weight write strobe
wr_addr_i  input  AW  weight address = j*N_IN + k (neuron j, input k)
wr_data_i  input  WW  signed weight value
in_valid_i  input  1  input vector valid
in_ready_o  output  1  block can accept a vector
x_i  input  N_IN*DW  packed inputs, x_k at [k*DW +: DW]
out_valid_o  output  1  result vector valid
out_ready_i  input  1  downstream accepts result
y_o  output  N_OUT*OW  packed outputs, y_j at [j*OW +: OW]
busy_o  output  1  high in MAC state
sat_o  output  1  some y_j clipped in the current result

Behaviour:
- Reset: all outputs 0, all weights 0, state IDLE, counters 0. Reset is asynchronous and active-high.
- States and transitions:
  - IDLE -> MAC on in_valid_i & in_ready_o & en_i.
  - MAC -> DONE after the last product.
  - DONE -> IDLE on out_valid_o & out_ready_i.
- in_ready_o = (state==IDLE).
- Acceptance edge:
  - Latches x_i.
  - Clears sat_o.
  - Sets neuron index j=0, input index k=0, accumulator acc=0.
- MAC state:
  - Each enabled cycle: acc += $signed({1'b0,x_k}) * w[j*N_IN+k], sign-extended to ACC_W. Then k++.
  - When k==N_IN-1, the finished sum (acc plus the final product) goes through ReLU and saturation into y_j. Then acc=0, k=0, j++.
  - ReLU/saturation rule: negative -> 0; value > 2^OW-1 -> 2^OW-1 and set sat_o; otherwise the low OW bits.
  - After neuron N_OUT-1 completes, go to DONE.
- Latency: out_valid_o rises N_IN*N_OUT enabled cycles after the acceptance edge (32 with defaults).
- DONE: out_valid_o=1. y_o and sat_o are held stable until the handshake.
  - y_o retains its value after the handshake, until neurons are overwritten in the next MAC pass.
- en_i=0:
  - State, counters and accumulator freeze.
  - No new acceptance.
  - An output handshake still completes.
  - Weight writes still complete.
- Weight writes:
  - Take effect at the clock edge when state!=MAC.
  - wr_en_i during MAC is ignored (dropped, no side effect).
  - Addresses >= N_IN*N_OUT are ignored.
  - A write in the same cycle as acceptance takes effect and is used by the transaction.
- Reset mid-MAC aborts the transaction. Weights and outputs return to 0.

Optional Feature:
- Macro NEURON_LAYER_BIAS_EN.
- When defined:
  - Adds N_OUT signed WW-bit bias registers (reset 0), writable at addresses N_IN*N_OUT + j.
  - AW becomes $clog2(N_IN*N_OUT+N_OUT).
  - The accumulator for neuron j starts at sign-extended bias_j instead of 0.
  - ACC_W grows by 1.
- When undefined:
  - No bias storage.
  - Addresses above the weight range are ignored.

Decomposition:
- Shared package nn_pkg holds:
  - state enum {IDLE, MAC, DONE};
  - ACC_W/AW width-calculation functions;
  - relu_sat function (signed acc -> unsigned OW with a sat flag).
- One sub-module, nn_mac_unit: the combinational signed multiply, accumulator register, clear/load, and relu_sat output.
- FSM, counters and weight file stay in neuron_layer_mac.

Test Plan:
- Weights per neuron {1,2,3,4}, all x=0xA -> every y_j=100, sat_o=0, out_valid_o exactly 32 cycles after acceptance.
- All weights -8, all x=0xF -> every y_j=0 (ReLU), sat_o=0.
- OW=8, all weights 7, all x=0xF (sum 420) -> every y_j=255, sat_o=1. Next transaction with x=0 -> y_j=0, sat_o=0.
- Backpressure and write-drop:
  - Hold out_ready_i low 5 cycles after out_valid_o -> y_o stable, in_ready_o=0 throughout.
  - A second in_valid_i is not accepted until the cycle after the handshake.
  - wr_en_i during MAC leaves the weights unchanged (verify by re-running).
- en_i low for 3 cycles mid-MAC -> result identical, latency 35.
- Assert rst_i at cycle 10 of MAC (asynchronous, mid-cycle) -> out_valid_o/busy_o/y_o drop to 0 immediately. A following transaction without weight writes yields all y_j=0.
